timestamp_decoder: RTL and testbench

- Consumer end of the timestamp word stream. Pops 32-bit words from an upstream FIFO read port and checks the 4-bit identifier and the word-type sequence 1, 2, 3.
- Reassembles each valid triple into a 64-bit timestamp and presents it on a valid/ready output.
- Used in test firmware and loopback checks. It sits between a timestamp FIFO and downstream logic, and has an 8-bit bus register interface on BUS_CLK.

---
 rtl/timestamp_decoder.sv | 171 +++++++++++++++++
 tb/tb_timestamp_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_decoder.sv
// rtl/timestamp_decoder.sv - checks and reassembles 1/2/3 timestamp word triples from a FIFO
//
// Pops 32-bit words from an upstream FIFO (one word per 3 cycles at most),
// checks the identifier nibble and the type sequence 1,2,3, and presents each
// complete triple as a 64-bit timestamp on a valid/ready output.
//
// Ports:
//   BUS_CLK       clock for all logic
//   RST           synchronous active-high reset
//   FIFO_EMPTY    upstream FIFO empty flag
//   FIFO_READ     one-cycle pop strobe; FIFO_DATA is valid the following cycle
//   FIFO_DATA     upstream word {id[31:28], type[27:24], payload[23:0]}
//   TS_DATA       reassembled timestamp {w3[15:0], w2[23:0], w1[23:0]}
//   TS_VALID      TS_DATA valid, held until TS_READY
//   TS_READY      downstream accepts TS_DATA
//   BUS_ADD       register address
//   BUS_DATA_IN   register write data
//   BUS_DATA_OUT  registered read data
//   BUS_WR        register write strobe (address 0 = soft reset)
//   BUS_RD        register read strobe
module timestamp_decoder #(
  parameter int unsigned ABUSWIDTH  = 16,
  parameter logic [3:0]  IDENTIFIER = 4'b0001
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 FIFO_EMPTY,
  output logic                 FIFO_READ,
  input  logic [31:0]          FIFO_DATA,
  output logic [63:0]          TS_DATA,
  output logic                 TS_VALID,
  input  logic                 TS_READY,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD
);

  localparam logic [7:0] VERSION = 8'd1;

  typedef enum logic [1:0] {IDLE, READ, CHECK} state_t;

  state_t      state_q;
  logic        fifo_read_q;
  logic        ts_valid_q;
  logic [63:0] ts_data_q;
  logic        conf_en_q;
  logic [7:0]  seq_err_q;
  logic [7:0]  id_err_q;
  logic [15:0] ts_cnt_q;
  logic [1:0]  exp_q;
  logic [47:0] buf_q;
  logic [7:0]  bus_data_q;

  logic        soft_rst;
  logic        rst_int;
  logic [3:0]  id_w;
  logic [3:0]  typ_w;
  logic [47:0] buf_d;
  logic [1:0]  exp_d;
  logic        emit_w;
  logic        seq_inc_w;
  logic        id_inc_w;

  assign soft_rst = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
  assign rst_int  = RST || soft_rst;

  assign id_w  = FIFO_DATA[31:28];
  assign typ_w = FIFO_DATA[27:24];

  // Word decode; only consumed while in CHECK, where FIFO_DATA is valid.
  always_comb begin
    buf_d     = buf_q;
    exp_d     = exp_q;
    emit_w    = 1'b0;
    seq_inc_w = 1'b0;
    id_inc_w  = 1'b0;
    if (id_w != IDENTIFIER) begin
      // Foreign words do not disturb the frame in progress.
      id_inc_w = 1'b1;
    end else if (typ_w == 4'd1 && exp_q == 2'd1) begin
      buf_d[23:0] = FIFO_DATA[23:0];
      exp_d       = 2'd2;
    end else if (typ_w == 4'd2 && exp_q == 2'd2) begin
      buf_d[47:24] = FIFO_DATA[23:0];
      exp_d        = 2'd3;
    end else if (typ_w == 4'd3 && exp_q == 2'd3 && FIFO_DATA[23:16] == 8'd0) begin
      emit_w = 1'b1;
      exp_d  = 2'd1;
    end else begin
      seq_inc_w = 1'b1;
      // An out-of-order type 1 is still a usable frame start.
      if (typ_w == 4'd1) begin
        buf_d[23:0] = FIFO_DATA[23:0];
        exp_d       = 2'd2;
      end else begin
        exp_d = 2'd1;
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_int) begin
      state_q     <= IDLE;
      fifo_read_q <= 1'b0;
      ts_valid_q  <= 1'b0;
      ts_data_q   <= '0;
      conf_en_q   <= 1'b0;
      seq_err_q   <= '0;
      id_err_q    <= '0;
      ts_cnt_q    <= '0;
      exp_q       <= 2'd1;
      buf_q       <= '0;
    end else begin
      fifo_read_q <= 1'b0;
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(2))
        conf_en_q <= BUS_DATA_IN[0];
      if (ts_valid_q && TS_READY)
        ts_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // CONF_EN only gates new pops; an outstanding READ/CHECK always finishes.
          if (conf_en_q && !FIFO_EMPTY && !ts_valid_q) begin
            state_q     <= READ;
            fifo_read_q <= 1'b1;
          end
        end
        READ: state_q <= CHECK;
        CHECK: begin
          state_q <= IDLE;
          buf_q   <= buf_d;
          exp_q   <= exp_d;
          if (emit_w) begin
            ts_data_q  <= {FIFO_DATA[15:0], buf_q};
            ts_valid_q <= 1'b1;
            ts_cnt_q   <= ts_cnt_q + 16'd1;
          end
          if (seq_inc_w && seq_err_q != 8'hFF)
            seq_err_q <= seq_err_q + 8'd1;
          if (id_inc_w && id_err_q != 8'hFF)
            id_err_q <= id_err_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data sees only RST, so a read of VERSION alongside a soft reset still returns it.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      bus_data_q <= '0;
    end else if (BUS_RD) begin
      case (BUS_ADD)
        ABUSWIDTH'(0): bus_data_q <= VERSION;
        ABUSWIDTH'(2): bus_data_q <= {7'd0, conf_en_q};
        ABUSWIDTH'(3): bus_data_q <= seq_err_q;
        ABUSWIDTH'(4): bus_data_q <= id_err_q;
        ABUSWIDTH'(5): bus_data_q <= ts_cnt_q[7:0];
        ABUSWIDTH'(6): bus_data_q <= ts_cnt_q[15:8];
        default:       bus_data_q <= '0;
      endcase
    end
  end

  assign FIFO_READ    = fifo_read_q;
  assign TS_VALID     = ts_valid_q;
  assign TS_DATA      = ts_data_q;
  assign BUS_DATA_OUT = bus_data_q;

endmodule

// File: tb/tb_timestamp_decoder.sv
// tb/tb_timestamp_decoder.sv - self-checking bench for timestamp_decoder
module tb_timestamp_decoder;

  logic        BUS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_EMPTY = 1'b1;
  logic        FIFO_READ;
  logic [31:0] FIFO_DATA = '0;
  logic [63:0] TS_DATA;
  logic        TS_VALID;
  logic        TS_READY = 1'b0;
  logic [15:0] BUS_ADD = '0;
  logic [7:0]  BUS_DATA_IN = '0;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_WR = 1'b0;
  logic        BUS_RD = 1'b0;

  timestamp_decoder #(.ABUSWIDTH(16), .IDENTIFIER(4'b0001)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_READ(FIFO_READ),
    .FIFO_DATA(FIFO_DATA), .TS_DATA(TS_DATA), .TS_VALID(TS_VALID), .TS_READY(TS_READY),
    .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN), .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_WR(BUS_WR), .BUS_RD(BUS_RD)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [31:0] fifo_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_ts[$];

  // Reference model state: frame position, collected payload parts, counters.
  int m_exp = 1, m_seq = 0, m_id = 0, m_cnt = 0;
  logic [63:0] m_lo = '0, m_mid = '0;

  // Upstream FIFO: data appears the cycle after the pop strobe.
  always @(posedge BUS_CLK) begin
    if (FIFO_READ) begin
      pops <= pops + 1;
      if (fifo_q.size() > 0) FIFO_DATA <= fifo_q.pop_front();
    end
  end
  always @(negedge BUS_CLK) FIFO_EMPTY <= (fifo_q.size() == 0);

  always @(posedge BUS_CLK) if (TS_VALID && TS_READY) got_q.push_back(TS_DATA);

  task automatic model_reset();
    m_exp = 1; m_seq = 0; m_id = 0; m_cnt = 0; m_lo = '0; m_mid = '0;
    exp_ts.delete(); got_q.delete();
  endtask

  task automatic model_word(input logic [31:0] w);
    int unsigned id, typ, pl;
    id = w >> 28; typ = (w >> 24) & 32'hF; pl = w & 32'hFF_FFFF;
    if (id != 1) begin
      if (m_id < 255) m_id++;
    end else if (typ == m_exp && (typ != 3 || pl < 65536)) begin
      if (typ == 1) m_lo = 64'(pl);
      else if (typ == 2) m_mid = 64'(pl);
      else begin
        exp_ts.push_back((64'(pl) << 48) | (m_mid << 24) | m_lo);
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_exp = (m_exp == 3) ? 1 : m_exp + 1;
    end else begin
      if (m_seq < 255) m_seq++;
      if (typ == 1) begin m_lo = 64'(pl); m_exp = 2; end
      else m_exp = 1;
    end
  endtask

  task automatic send(input logic [31:0] w);
    fifo_q.push_back(w);
    model_word(w);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
    @(posedge BUS_CLK); #1;
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    BUS_ADD = a; BUS_RD = 1'b1;
    @(posedge BUS_CLK); #1;
    BUS_RD = 1'b0; d = BUS_DATA_OUT;
  endtask

  // Runs until the FIFO is empty and the DUT has been quiet for several cycles.
  task automatic drain(input bit rand_ready, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge BUS_CLK); #1;
      TS_READY = rand_ready ? 1'($urandom % 2) : 1'b1;
      if (fifo_q.size() == 0 && !TS_VALID && !FIFO_READ) quiet++; else quiet = 0;
      if (quiet >= 6) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_counters(input string tag);
    logic [7:0] d;
    bus_read(16'd3, d); total++;
    if (d !== 8'(m_seq)) begin bad++; $display("FAIL %s seq_err got=%0d exp=%0d", tag, d, m_seq); end
    bus_read(16'd4, d); total++;
    if (d !== 8'(m_id)) begin bad++; $display("FAIL %s id_err got=%0d exp=%0d", tag, d, m_id); end
    bus_read(16'd5, d); total++;
    if (d !== 8'(m_cnt)) begin bad++; $display("FAIL %s ts_cnt_lo got=%0d exp=%0d", tag, d, m_cnt & 255); end
    bus_read(16'd6, d); total++;
    if (d !== 8'(m_cnt >> 8)) begin bad++; $display("FAIL %s ts_cnt_hi got=%0d exp=%0d", tag, d, m_cnt >> 8); end
  endtask

  task automatic check_outputs(input string tag);
    total++;
    if (got_q.size() != exp_ts.size()) begin
      bad++; $display("FAIL %s ts_count got=%0d exp=%0d", tag, got_q.size(), exp_ts.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_ts.size(); i++) begin
      total++;
      if (got_q[i] !== exp_ts[i]) begin
        bad++; $display("FAIL %s ts[%0d] got=%h exp=%h", tag, i, got_q[i], exp_ts[i]);
      end
    end
    got_q.delete(); exp_ts.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(posedge BUS_CLK);
    #1 RST = 1'b0;
    total++; if (TS_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", TS_VALID); end
    total++; if (FIFO_READ !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", FIFO_READ); end
    total++; if (TS_DATA !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", TS_DATA); end
    bus_read(16'd0, d); total++;
    if (d !== 8'd1) begin bad++; $display("FAIL version got=%0d exp=1", d); end
    bus_read(16'd2, d); total++;
    if (d !== 8'd0) begin bad++; $display("FAIL reset_conf got=%0d exp=0", d); end
    bus_read(16'd9, d); total++;
    if (d !== 8'd0) begin bad++; $display("FAIL unmapped got=%0d exp=0", d); end
    check_counters("reset");
  endtask

  task automatic test_basic();
    int p0, c;
    bit ok;
    bus_write(16'd2, 8'h01);
    TS_READY = 1'b0; p0 = pops;
    send(32'h1123_4567); send(32'h1289_ABCD); send(32'h1300_EF01);
    for (c = 0; c < 60 && !TS_VALID; c++) begin @(posedge BUS_CLK); #1; end
    total++; if (TS_VALID !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", TS_VALID); end
    total++;
    if (TS_DATA !== 64'hEF01_89AB_CD23_4567) begin bad++; $display("FAIL basic_data got=%h exp=ef0189abcd234567", TS_DATA); end
    repeat (5) @(posedge BUS_CLK); #1;
    total++; if (pops - p0 != 3) begin bad++; $display("FAIL basic_pops got=%0d exp=3", pops - p0); end
    check_counters("basic");
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_drain got=timeout exp=idle"); end
    check_outputs("basic");
  endtask

  task automatic test_seq_err();
    bit ok;
    send(32'h1100_0001); send(32'h1300_0003);
    send(32'h1100_002A); send(32'h1200_0000); send(32'h1300_0000);
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL seq_drain got=timeout exp=idle"); end
    total++; if (m_seq != 1 || exp_ts.size() != 1 || exp_ts[0] != 64'h2A) begin
      bad++; $display("FAIL seq_model got=%0d exp=1", m_seq);
    end
    check_outputs("seq");
    check_counters("seq");
  endtask

  task automatic test_id_err();
    bit ok;
    logic [23:0] a, b;
    a = 24'($urandom); b = 24'($urandom);
    send({8'h11, a}); send(32'h2100_0005); send({8'h12, b}); send({8'h13, 8'h00, 16'($urandom)});
    drain(1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL id_drain got=timeout exp=idle"); end
    check_outputs("id");
    check_counters("id");
  endtask

  task automatic test_back_to_back();
    int c, p0, hold_bad;
    bit ok;
    logic [63:0] d0;
    TS_READY = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send({8'h11, 24'($urandom)}); send({8'h12, 24'($urandom)}); send({8'h13, 8'h00, 16'($urandom)});
    end
    for (c = 0; c < 60 && !TS_VALID; c++) begin @(posedge BUS_CLK); #1; end
    total++; if (TS_VALID !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", TS_VALID); end
    d0 = TS_DATA; p0 = pops; hold_bad = 0;
    repeat (20) begin
      @(posedge BUS_CLK); #1;
      if (TS_DATA !== d0 || TS_VALID !== 1'b1) hold_bad++;
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL b2b_hold got=%0d exp=0", hold_bad); end
    total++; if (pops != p0) begin bad++; $display("FAIL b2b_pops got=%0d exp=%0d", pops, p0); end
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_drain got=timeout exp=idle"); end
    total++; if (TS_DATA !== exp_ts[exp_ts.size()-1]) begin bad++; $display("FAIL b2b_hold_last got=%h exp=%h", TS_DATA, exp_ts[exp_ts.size()-1]); end
    check_outputs("b2b");
  endtask

  task automatic test_saturate();
    bit ok;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) send({8'h12, 24'($urandom)});
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_drain got=timeout exp=idle"); end
    bus_read(16'd3, d); total++;
    if (d !== 8'd255) begin bad++; $display("FAIL sat_seq got=%0d exp=255", d); end
    check_counters("sat");
    bus_write(16'd0, 8'h00);
    model_reset();
    total++; if (TS_DATA !== 64'd0) begin bad++; $display("FAIL soft_data got=%h exp=0", TS_DATA); end
    bus_read(16'd2, d); total++;
    if (d !== 8'd0) begin bad++; $display("FAIL soft_conf got=%0d exp=0", d); end
    check_counters("soft");
  endtask

  task automatic test_disable();
    int p0;
    bit ok;
    bus_write(16'd2, 8'h01);
    send({8'h11, 24'($urandom)}); send({8'h12, 24'($urandom)});
    drain(1'b0, ok);
    bus_write(16'd2, 8'h00);
    p0 = pops;
    send({8'h13, 8'h00, 16'($urandom)});
    repeat (15) @(posedge BUS_CLK); #1;
    total++; if (pops != p0) begin bad++; $display("FAIL dis_pops got=%0d exp=%0d", pops, p0); end
    bus_write(16'd2, 8'h01);
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL dis_drain got=timeout exp=idle"); end
    check_outputs("dis");
    check_counters("dis");
  endtask

  task automatic test_random();
    bit ok;
    int unsigned id, typ;
    for (int i = 0; i < 150; i++) begin
      id = ($urandom % 6 == 0) ? 2 : 1;
      typ = ($urandom % 5 == 0) ? $urandom % 5 : m_exp;
      if (typ == 3 && $urandom % 8 != 0) send({4'(id), 4'(typ), 8'h00, 16'($urandom)});
      else send({4'(id), 4'(typ), 24'($urandom)});
    end
    drain(1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain got=timeout exp=idle"); end
    check_outputs("rand");
    check_counters("rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seq_err();
    test_id_err();
    test_back_to_back();
    test_saturate();
    test_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
